alu_t_c3x3_result_reader: RTL

ALU_T_C3X3_RESULT_READER -- requirements
Module: alu_t_c3x3_result_reader

---
 rtl/alu_t_c3x3_result_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_t_c3x3_result_reader.sv
// Collects bursts of ALU sum beats into either one wide 27x27 accumulator or
// three isolated 18-bit-lane accumulators, then holds the result until it is taken.
module alu_t_c3x3_result_reader #(
  parameter int ACC_W_FULL = 64,
  parameter int ACC_W_LANE = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        USE_SIMD,
  input  logic [53:0] S,
  input  logic [5:0]  result_SIMD_carry_out,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [5:0]  result_SIMD_carry_in,
  output logic [71:0] out_data,
  output logic [7:0]  out_count,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                state;
  logic                  mode;
  logic [ACC_W_FULL-1:0] acc_full;
  logic [ACC_W_LANE-1:0] acc_lane [3];
  logic [ACC_W_LANE-1:0] beat_lane [3];
  logic [ACC_W_LANE:0]   sum_lane [3];
  logic [ACC_W_FULL-1:0] beat_full;
  logic [ACC_W_FULL:0]   sum_full;
  logic [7:0]            count;
  logic                  ovf;
  logic                  valid_q;
  logic                  lane_wrap;
  logic                  wrap;
  logic                  take;

  assign result_SIMD_carry_in = '0;
  assign in_ready  = reset && (state != DRAIN);
  assign take      = in_valid && in_ready;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_valid = valid_q;

  // Only the top segment's carry extends the chained 54-bit sum; lane carries stay per lane.
  always_comb begin
    beat_full = ACC_W_FULL'({result_SIMD_carry_out[5:4], S});
    sum_full  = {1'b0, acc_full} + {1'b0, beat_full};
    lane_wrap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat_lane[k] = ACC_W_LANE'({result_SIMD_carry_out[2*k+1 -: 2], S[18*k +: 18]});
      sum_lane[k]  = {1'b0, acc_lane[k]} + {1'b0, beat_lane[k]};
      lane_wrap    = lane_wrap | sum_lane[k][ACC_W_LANE];
    end
    wrap = mode ? lane_wrap : sum_full[ACC_W_FULL];
  end

  always_comb begin
    out_data = 72'(acc_full);
    if (mode) begin
      out_data = {24'(acc_lane[2]), 24'(acc_lane[1]), 24'(acc_lane[0])};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode     <= 1'b0;
      acc_full <= '0;
      for (int k = 0; k < 3; k++) acc_lane[k] <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First beat loads rather than adds and starts a fresh overflow history.
          if (take) begin
            mode     <= USE_SIMD;
            acc_full <= beat_full;
            for (int k = 0; k < 3; k++) acc_lane[k] <= beat_lane[k];
            count    <= 8'd1;
            ovf      <= 1'b0;
            if (in_last) begin
              state   <= DRAIN;
              valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            acc_full <= sum_full[ACC_W_FULL-1:0];
            for (int k = 0; k < 3; k++) acc_lane[k] <= sum_lane[k][ACC_W_LANE-1:0];
            if (count != 8'hFF) count <= count + 8'd1;
            ovf <= ovf | wrap | (count == 8'hFF);
            if (in_last) begin
              state   <= DRAIN;
              valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
